requant_pipe: RTL and testbench
===============================

Name: requant_pipe

Overview:
- Post-processing stage directly downstream of the MAC accumulator CFU.
- Consumes 32-bit signed accumulator results and applies TFLite-style requantization: bias add, saturating rounding doubling high multiply, rounding right shift, output offset, activation clamp.
- Emits int8 activations through a 4-stage pipeline with valid/ready handshake on both sides.
- A small register file, written while the pipeline is idle, holds the quantization parameters.

Parameters:
- OUT_W, 8, output activation width in bits; clamp bounds are sign-extended to 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  accumulator word valid
- in_ready  out  1  stage can accept a word
- in_acc  in  32  signed accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  signed requantized activation
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  config register select
- cfg_data  in  32  config write data
- cfg_err  out  1  one-cycle pulse: config write rejected
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Config registers and reset values:
  - addr 0, bias int32: reset 0.
  - addr 1, multiplier int32: reset 0x40000000.
  - addr 2, packed fields: [4:0] shift, unsigned right shift 0..31, reset 0; [23:16] act_min, reset -128; [31:24] act_max, reset 127. Bits [15:5] are ignored.
  - addr 3, out_offset int32: reset 0.
- Config write timing:
  - A write takes effect on the next cycle only when busy=0 and no input is accepted in the same cycle.
  - Otherwise the write is dropped and cfg_err=1 for exactly one cycle.
- Handshake:
  - advance = !(v4 && !out_ready), where v1..v4 are the stage valid bits.
  - in_ready = advance.
  - A word is accepted on in_valid && in_ready.
  - When advance=1, every stage shifts forward one stage per cycle.
  - When advance=0, every stage holds.
  - out_valid = v4; out_data is held stable while out_valid && !out_ready.
  - busy = v1|v2|v3|v4.
  - Latency is 4 cycles from acceptance to out_valid, with no stalls.
  - Throughput is 1 word per cycle.
- S1: x1 = in_acc + bias, 32-bit two's complement, wrapping with no saturation.
- S2: saturating rounding doubling high multiply with m = multiplier.
  - If x1 == m == 0x80000000, then x2 = 0x7FFFFFFF.
  - Otherwise p = x1*m as a full 64-bit signed product.
  - nudge = 2^30 if p >= 0, else 1 - 2^30.
  - x2 = (p + nudge) / 2^31, truncated toward zero, low 32 bits.
- S3: rounding divide by 2^s, where s = shift.
  - mask = 2^s - 1; rem = x2 & mask.
  - thr = (mask >> 1) + (x2 < 0).
  - x3 = (x2 >>> s) + (rem > thr). For s = 0, x3 = x2.
- S4: y = x3 + out_offset, wrapping.
  - out_data = min(max(y, act_min), act_max).
  - If act_min > act_max, the result is act_max.
- Config values are read combinationally at each stage. This is legal because config writes are only honoured while the pipeline is empty.
- Reset, including mid-operation:
  - All valid bits clear; out_valid=0, cfg_err=0, busy=0, out_data=0.
  - Config returns to its reset values.
  - Any in-flight words are discarded.
- Simultaneous accept and output handshake in the same cycle is legal, with no bubble.

Test Plan:
- Default config, acc=100 -> 4 cycles later out_data=50. With acc=-6 -> -3.
- mult=0x40000000, shift=1, acc=5 -> 2; acc=-6 -> -2, rounding half away from zero.
- mult=0x80000000, bias=0, acc=0x80000000 -> x2=0x7FFFFFFF, clamped to out_data=127. Separately, acc=0x7FFFFFFF with bias=1 -> x1 wraps to 0x80000000.
- out_ready=0, stream of 6 words on consecutive cycles:
  - Exactly 4 words are accepted; in_ready drops the cycle after the 4th acceptance.
  - out_data stays stable.
  - On release of out_ready, all 6 words emerge in order with no loss or duplication.
- cfg_we to addr 0 while busy=1 -> cfg_err pulses for 1 cycle and bias is unchanged. The same write with busy=0 -> applied; the next word reflects the new bias.
- Assert reset with 3 words in flight -> the next cycle out_valid=0 and busy=0, with config back to defaults. A subsequent acc=100 yields 50.

Source files
------------

// File: rtl/requant_pipe.sv
// requant_pipe: 4-stage int32 -> int8 requantizer behind the MAC CFU.
// Bias, SRDHM multiply, rounding shift, offset and clamp, one per stage.
module requant_pipe #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  output logic             cfg_err,
  output logic             busy
);

  logic [31:0] bias, mult, offs;
  logic [4:0]  shift;
  logic [7:0]  act_min, act_max;

  logic v1, v2, v3, v4;
  logic [31:0] x1, x2, x3;
  logic [OUT_W-1:0] q4;

  logic advance, accept, cfg_ok;

  logic [31:0] s1, s2, s3;
  logic [OUT_W-1:0] s4;
  logic signed [63:0] a64, b64, p, nudge, pn, pq;
  logic [31:0] mask, rem, thr, sh;
  logic [31:0] y, lo, hi, c;
  logic unused_bits;

  assign advance   = !(v4 && !out_ready);
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign busy      = v1 | v2 | v3 | v4;
  assign out_valid = v4;
  assign out_data  = q4;
  // Parameters may only change while nothing is in flight or entering.
  assign cfg_ok    = !busy && !accept;

  // Per-stage arithmetic; config is read live since it is frozen while busy.
  always_comb begin
    s1 = in_acc + bias;

    a64   = {{32{x1[31]}}, x1};
    b64   = {{32{mult[31]}}, mult};
    p     = a64 * b64;
    nudge = p[63] ? 64'sd1 - 64'sd1073741824 : 64'sd1073741824;
    pn    = p + nudge;
    // Arithmetic shift floors; bias negatives so the divide truncates to zero.
    pq    = pn[63] ? (pn + 64'sd2147483647) >>> 31 : pn >>> 31;
    if (x1 == 32'h8000_0000 && mult == 32'h8000_0000)
      s2 = 32'h7FFF_FFFF;
    else
      s2 = pq[31:0];

    mask = (32'd1 << shift) - 32'd1;
    rem  = x2 & mask;
    thr  = (mask >> 1) + {31'd0, x2[31]};
    sh   = $signed(x2) >>> shift;
    s3   = sh + {31'd0, rem > thr};

    y  = x3 + offs;
    lo = {{24{act_min[7]}}, act_min};
    hi = {{24{act_max[7]}}, act_max};
    c  = ($signed(y) < $signed(lo)) ? lo : y;
    c  = ($signed(c) > $signed(hi)) ? hi : c;
    s4 = c[OUT_W-1:0];

    unused_bits = ^{cfg_data[15:5], pq[63:32], c[31:OUT_W]};
  end

  // Config register file; writes while busy or accepting are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias    <= 32'd0;
      mult    <= 32'h4000_0000;
      shift   <= 5'd0;
      act_min <= 8'h80;
      act_max <= 8'h7F;
      offs    <= 32'd0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        unique case (cfg_addr)
          2'd0: bias <= cfg_data;
          2'd1: mult <= cfg_data;
          2'd2: begin
            shift   <= cfg_data[4:0];
            act_min <= cfg_data[23:16];
            act_max <= cfg_data[31:24];
          end
          2'd3: offs <= cfg_data;
        endcase
      end
    end
  end

  // Pipeline registers; the whole pipe moves or holds together.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
      x1 <= 32'd0;
      x2 <= 32'd0;
      x3 <= 32'd0;
      q4 <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      x1 <= s1;
      x2 <= s2;
      x3 <= s3;
      q4 <= s4;
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: directed vectors plus stall, config and reset sequences.
`timescale 1ns/1ps
module tb_requant_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_err;
  logic        busy;

  int tests;
  int failed;

  requant_pipe #(.OUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bias;
    logic [31:0] mult;
    logic [31:0] pk;
    logic [31:0] offs;
    logic [31:0] acc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_one(input logic [31:0] acc, input logic [7:0] exp,
                          input string name);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_acc = acc;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      n++;
      tick();
    end
    chk(name, {24'd0, out_data}, {24'd0, exp});
    chk({name, "_lat"}, 32'(n), 32'd3);
    tick();
  endtask

  logic [31:0] words[6];
  logic [7:0]  wexp[6];
  int sent, rcvd, bad;
  logic have, a_now, o_now;
  logic [7:0] hold;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0;
    failed = 0;
    vecs[0]  = '{32'd0, 32'h4000_0000, 32'h7F80_0000, 32'd0, 32'd100, 8'h32};
    vecs[1]  = '{32'd0, 32'h4000_0000, 32'h7F80_0000, 32'd0, 32'hFFFF_FFFA, 8'hFD};
    vecs[2]  = '{32'd0, 32'h4000_0000, 32'h7F80_0001, 32'd0, 32'd5, 8'h02};
    vecs[3]  = '{32'd0, 32'h4000_0000, 32'h7F80_0001, 32'd0, 32'hFFFF_FFFA, 8'hFE};
    vecs[4]  = '{32'd0, 32'h8000_0000, 32'h7F80_0000, 32'd0, 32'h8000_0000, 8'h7F};
    vecs[5]  = '{32'd1, 32'h4000_0000, 32'h7F80_0000, 32'd0, 32'h7FFF_FFFF, 8'h80};
    vecs[6]  = '{32'd0, 32'h4000_0000, 32'h7F80_0004, 32'd0, 32'd1000, 8'h1F};
    vecs[7]  = '{32'd0, 32'h4000_0000, 32'h0A14_0000, 32'd0, 32'd0, 8'h0A};
    vecs[8]  = '{32'd0, 32'h4000_0000, 32'h7F80_0000, 32'd0, 32'd1000, 8'h7F};
    vecs[9]  = '{32'd0, 32'h4000_0000, 32'h7F80_0000, 32'hFFFF_FFC4, 32'd100, 8'hF6};
    vecs[10] = '{32'd0, 32'h7FFF_FFFF, 32'h7F80_001F, 32'd0, 32'h7FFF_FFFF, 8'h01};
    vecs[11] = '{32'd0, 32'h4000_0000, 32'h7F80_0000, 32'd0, 32'hFFFF_FC18, 8'h80};

    reset = 1'b1;
    in_valid = 1'b0;
    in_acc = 32'd0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_one(32'd100, 8'h32, "default_100");

    for (int i = 0; i < 12; i++) begin
      cfg_write(2'd0, vecs[i].bias);
      cfg_write(2'd1, vecs[i].mult);
      cfg_write(2'd2, vecs[i].pk);
      cfg_write(2'd3, vecs[i].offs);
      send_one(vecs[i].acc, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      words[i] = 32'(10 * (i + 1));
      wexp[i] = 8'(5 * (i + 1));
    end
    sent = 0;
    rcvd = 0;
    bad = 0;
    have = 1'b0;
    hold = 8'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (sent < 6);
      in_acc = (sent < 6) ? words[sent] : 32'd0;
      #2;
      a_now = in_valid && in_ready;
      if (out_valid) begin
        if (!have) begin
          hold = out_data;
          have = 1'b1;
        end else if (out_data != hold) begin
          bad++;
        end
      end
      tick();
      if (a_now) sent++;
    end
    chk("stall_accepted", 32'(sent), 32'd4);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_first", {24'd0, hold}, 32'd5);
    chk("stall_hold", 32'(bad), 32'd0);

    out_ready = 1'b1;
    for (int k = 0; k < 40 && rcvd < 6; k++) begin
      in_valid = (sent < 6);
      in_acc = (sent < 6) ? words[sent] : 32'd0;
      #2;
      a_now = in_valid && in_ready;
      o_now = out_valid && out_ready;
      if (o_now) begin
        chk($sformatf("drain%0d", rcvd), {24'd0, out_data}, {24'd0, wexp[rcvd]});
        rcvd++;
      end
      tick();
      if (a_now) sent++;
    end
    in_valid = 1'b0;
    chk("drain_count", 32'(rcvd), 32'd6);
    tick();
    tick();
    chk("drain_no_dup", {31'd0, out_valid}, 32'd0);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    in_valid = 1'b1;
    in_acc = 32'd100;
    tick();
    in_valid = 1'b0;
    cfg_write(2'd0, 32'd1000);
    chk("err_busy", {31'd0, cfg_err}, 32'd1);
    tick();
    chk("err_pulse_end", {31'd0, cfg_err}, 32'd0);
    repeat (6) tick();
    send_one(32'd100, 8'h32, "bias_kept");

    in_valid = 1'b1;
    in_acc = 32'd100;
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 32'd20;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b0;
    chk("err_accept", {31'd0, cfg_err}, 32'd1);
    repeat (6) tick();
    send_one(32'd100, 8'h32, "bias_kept2");

    cfg_write(2'd0, 32'd20);
    chk("cfg_ok_noerr", {31'd0, cfg_err}, 32'd0);
    send_one(32'd100, 8'h3C, "bias_new");

    in_valid = 1'b1;
    in_acc = 32'd100;
    repeat (3) tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_data", {24'd0, out_data}, 32'd0);
    send_one(32'd100, 8'h32, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
